// File: rtl/bpc_stripe_feeder_pkg.sv
// Shared types and defaults for the bpc stripe feeder.
package bpc_stripe_feeder_pkg;

  localparam int unsigned CB_W_DEF      = 8;
  localparam int unsigned CB_H_DEF      = 8;
  localparam int unsigned W_COEF_DEF    = 16;
  localparam int unsigned PLANE_GAP_DEF = 8;

  typedef enum logic [2:0] {
    FEED_IDLE,
    FEED_SCAN,
    FEED_EMIT,
    FEED_GAP,
    FEED_FIN
  } feed_state_t;

  // Index of the highest set bit; 0 for an all-zero input.
  function automatic logic [3:0] msb_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bpc_stripe_feeder_sm_conv.sv
// Two's complement to sign-magnitude converter; the most negative value
// saturates to the largest representable magnitude.
module sm_conv #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-2:0] neg_low;

  // Negate via low bits only; the sign bit of -x is never needed.
  always_comb begin
    neg_low = ~x[W-2:0] + {{(W-2){1'b0}}, 1'b1};
    y       = x;
    if (x[W-1]) begin
      if (x[W-2:0] == '0) y = '1;
      else                y = {1'b1, neg_low};
    end
  end

endmodule

// File: rtl/bpc_stripe_feeder.sv
// Reads a quantised code-block, finds its MSB plane, then replays it once
// per bit-plane as 4-row stripe-columns framed for the bpc.
module bpc_stripe_feeder
  import bpc_stripe_feeder_pkg::*;
#(
  parameter int unsigned CB_W      = CB_W_DEF,
  parameter int unsigned CB_H      = CB_H_DEF,
  parameter int unsigned W_COEF    = W_COEF_DEF,
  parameter int unsigned PLANE_GAP = PLANE_GAP_DEF
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             zero_block,
  output logic                             mem_rd,
  output logic [$clog2(CB_W*CB_H/4)-1:0]   mem_addr,
  input  logic [4*W_COEF-1:0]              mem_q,
  output logic [W_COEF-1:0]                coeff0,
  output logic [W_COEF-1:0]                coeff1,
  output logic [W_COEF-1:0]                coeff2,
  output logic [W_COEF-1:0]                coeff3,
  output logic                             coef_en,
  output logic                             first_row,
  output logic                             first_col,
  output logic                             last_col,
  output logic                             first_plane,
  output logic [3:0]                       bit_pos,
  output logic                             plane_start,
  output logic                             plane_end
);

  localparam int unsigned N   = CB_W * CB_H / 4;
  localparam int unsigned AW  = $clog2(N);
  localparam int unsigned CLW = $clog2(CB_W);
  localparam int unsigned MW  = W_COEF - 1;
  localparam int unsigned CW  = $clog2(N + PLANE_GAP + 4);

  localparam logic [CW-1:0] CNT_N  = CW'(N);
  localparam logic [CW-1:0] CNT_N1 = CW'(N + 1);
  localparam logic [CW-1:0] CNT_GL = CW'(PLANE_GAP - 1);
  localparam logic [CW-1:0] CNT_W  = CW'(CB_W);
  localparam logic [CW-1:0] CNT_1  = CW'(1);

  feed_state_t state, state_next;

  logic [CW-1:0]     cnt;
  logic [MW-1:0]     acc;
  logic [MW-1:0]     mag_or;
  logic [MW-1:0]     acc_all;
  logic              zflag;
  logic              rd_issue;
  logic              scan_v1;
  logic              emit_v1;
  logic              fr1, fc1, lc1;
  logic [W_COEF-1:0] sm [4];

  for (genvar g = 0; g < 4; g++) begin : g_conv
    sm_conv #(.W(W_COEF)) u_conv (
      .x (mem_q[g*W_COEF +: W_COEF]),
      .y (sm[g])
    );
  end

  // Saturated magnitudes feed the MSB search so -2^(W-1) does not claim an extra plane.
  always_comb begin
    mag_or  = sm[0][MW-1:0] | sm[1][MW-1:0] | sm[2][MW-1:0] | sm[3][MW-1:0];
    acc_all = acc | (scan_v1 ? mag_or : '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= FEED_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      FEED_IDLE: if (start) state_next = FEED_SCAN;
      FEED_SCAN: if (cnt == CNT_N) state_next = (acc_all == '0) ? FEED_FIN : FEED_EMIT;
      FEED_EMIT: if (cnt == CNT_N1) state_next = FEED_GAP;
      FEED_GAP:  if (cnt == CNT_GL) state_next = (bit_pos == 4'd0) ? FEED_FIN : FEED_EMIT;
      FEED_FIN:  state_next = FEED_IDLE;
      default:   state_next = FEED_IDLE;
    endcase
  end

  // Control outputs decoded from state and phase counter.
  always_comb begin
    rd_issue    = ((state == FEED_SCAN) || (state == FEED_EMIT)) && (cnt < CNT_N);
    mem_rd      = rd_issue;
    mem_addr    = rd_issue ? cnt[AW-1:0] : '0;
    busy        = (state != FEED_IDLE) && (state != FEED_FIN);
    done        = (state == FEED_FIN);
    zero_block  = (state == FEED_FIN) && zflag;
    plane_start = (state == FEED_EMIT) && (cnt == CNT_1);
    plane_end   = (state == FEED_GAP) && (cnt == CNT_GL);
  end

  // Phase counter, MSB accumulator, plane bookkeeping and 2-stage output pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      acc         <= '0;
      zflag       <= 1'b0;
      bit_pos     <= '0;
      first_plane <= 1'b0;
      scan_v1     <= 1'b0;
      emit_v1     <= 1'b0;
      fr1         <= 1'b0;
      fc1         <= 1'b0;
      lc1         <= 1'b0;
      coef_en     <= 1'b0;
      coeff0      <= '0;
      coeff1      <= '0;
      coeff2      <= '0;
      coeff3      <= '0;
      first_row   <= 1'b0;
      first_col   <= 1'b0;
      last_col    <= 1'b0;
    end else begin
      if (state_next != state || state == FEED_IDLE) cnt <= '0;
      else                                            cnt <= cnt + CNT_1;

      if (state == FEED_IDLE) begin
        acc   <= '0;
        zflag <= 1'b0;
      end else if (scan_v1) begin
        acc <= acc_all;
      end

      if (state == FEED_SCAN && cnt == CNT_N) begin
        zflag <= (acc_all == '0);
        if (acc_all != '0) begin
          bit_pos     <= msb_index(16'(acc_all));
          first_plane <= 1'b1;
        end
      end else if (state == FEED_GAP && cnt == CNT_GL && bit_pos != 4'd0) begin
        bit_pos     <= bit_pos - 4'd1;
        first_plane <= 1'b0;
      end else if (state == FEED_FIN) begin
        bit_pos     <= '0;
        first_plane <= 1'b0;
      end

      // Flags ride alongside the read so they line up with its data.
      scan_v1 <= rd_issue && (state == FEED_SCAN);
      emit_v1 <= rd_issue && (state == FEED_EMIT);
      fr1     <= cnt < CNT_W;
      fc1     <= cnt[CLW-1:0] == '0;
      lc1     <= &cnt[CLW-1:0];

      coef_en   <= emit_v1;
      coeff0    <= emit_v1 ? sm[0] : '0;
      coeff1    <= emit_v1 ? sm[1] : '0;
      coeff2    <= emit_v1 ? sm[2] : '0;
      coeff3    <= emit_v1 ? sm[3] : '0;
      first_row <= emit_v1 && fr1;
      first_col <= emit_v1 && fc1;
      last_col  <= emit_v1 && lc1;
    end
  end

endmodule

// File: tb/tb_bpc_stripe_feeder.sv
// Randomised self-checking bench for bpc_stripe_feeder with a cycle-level
// reference computed from block contents and plane timing arithmetic.
module tb_bpc_stripe_feeder;

  localparam int CB_W = 8;
  localparam int CB_H = 8;
  localparam int W    = 16;
  localparam int G    = 8;
  localparam int N    = CB_W * CB_H / 4;
  localparam int L    = N + 2 + G;
  localparam int MAXM = (1 << (W - 1)) - 1;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic           busy, done, zero_block, mem_rd;
  logic [3:0]     mem_addr;
  logic [4*W-1:0] mem_q = '0;
  logic [W-1:0]   coeff0, coeff1, coeff2, coeff3;
  logic           coef_en, first_row, first_col, last_col, first_plane;
  logic [3:0]     bit_pos;
  logic           plane_start, plane_end;

  int blk [N*4];
  int errors = 0;
  int checks = 0;

  bpc_stripe_feeder #(
    .CB_W      (CB_W),
    .CB_H      (CB_H),
    .W_COEF    (W),
    .PLANE_GAP (G)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .zero_block  (zero_block),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .coeff0      (coeff0),
    .coeff1      (coeff1),
    .coeff2      (coeff2),
    .coeff3      (coeff3),
    .coef_en     (coef_en),
    .first_row   (first_row),
    .first_col   (first_col),
    .last_col    (last_col),
    .first_plane (first_plane),
    .bit_pos     (bit_pos),
    .plane_start (plane_start),
    .plane_end   (plane_end)
  );

  always #5 clk = ~clk;

  function automatic logic [4*W-1:0] pack_word(input int a);
    logic [4*W-1:0] w;
    for (int r = 0; r < 4; r++) w[r*W +: W] = W'(blk[a*4+r]);
    return w;
  endfunction

  // Code-block buffer: one-cycle read latency.
  always @(posedge clk) if (mem_rd) mem_q <= pack_word(int'(mem_addr));

  function automatic int mag_ref(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return (m > MAXM) ? MAXM : m;
  endfunction

  function automatic int sm_ref(input int v);
    if (v == 0) return 0;
    if (v < 0)  return (1 << (W - 1)) + mag_ref(v);
    return v;
  endfunction

  function automatic int msb_ref();
    int mx, b;
    mx = 0;
    for (int i = 0; i < N*4; i++) if (mag_ref(blk[i]) > mx) mx = mag_ref(blk[i]);
    if (mx == 0) return -1;
    b = 0;
    while ((mx >> (b + 1)) != 0) b++;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_blk();
    for (int i = 0; i < N*4; i++) blk[i] = 0;
  endtask

  task automatic fill_random(input int mlim);
    int span, v;
    span = 1 << mlim;
    for (int i = 0; i < N*4; i++) begin
      if ($urandom_range(0, 3) == 0) v = 0;
      else v = int'($urandom_range(0, 2*span)) - span;
      if (v > MAXM) v = MAXM;
      blk[i] = v;
    end
  endtask

  function automatic logic [63:0] idle_outputs();
    return {busy, done, zero_block, mem_rd, mem_addr, coef_en, first_row, first_col,
            last_col, first_plane, bit_pos, plane_start, plane_end};
  endfunction

  // Runs one block from start; restart_c > 0 re-pulses start at that cycle.
  task automatic run_block(input int restart_c);
    int m, pn, d, en_cnt, k, o, a;
    bit in_pl, e_en, e_rd;
    logic [63:0] exp_q;
    m  = msb_ref();
    pn = m + 1;
    d  = N + 2 + pn * L;
    en_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= d + 1; c++) begin
      in_pl = (c >= N + 2) && (c < d);
      k = in_pl ? (c - (N + 2)) / L : 0;
      o = in_pl ? (c - (N + 2)) % L : 0;
      e_en = in_pl && (o >= 2) && (o <= N + 1);
      e_rd = ((c >= 1) && (c <= N)) || (in_pl && (o < N));
      chk("busy", busy, c < d);
      chk("done", done, c == d);
      if (c == d) chk("zero_block", zero_block, m < 0);
      chk("coef_en", coef_en, e_en);
      chk("plane_start", plane_start, in_pl && (o == 1));
      chk("plane_end", plane_end, in_pl && (o == L - 1));
      chk("mem_rd", mem_rd, e_rd);
      if (e_rd) chk("mem_addr", mem_addr, (c <= N) ? c - 1 : o);
      if (in_pl) begin
        chk("bit_pos", bit_pos, m - k);
        chk("first_plane", first_plane, k == 0);
      end
      exp_q = '0;
      if (e_en) begin
        a = o - 2;
        exp_q = {16'(sm_ref(blk[a*4+3])), 16'(sm_ref(blk[a*4+2])),
                 16'(sm_ref(blk[a*4+1])), 16'(sm_ref(blk[a*4]))};
        chk("flags", {first_row, first_col, last_col},
            {a < CB_W, (a % CB_W) == 0, (a % CB_W) == CB_W - 1});
      end
      if (c < d) chk("coeffs", {coeff3, coeff2, coeff1, coeff0}, exp_q);
      if (coef_en) en_cnt++;
      start = (c == restart_c);
      @(negedge clk);
    end
    start = 1'b0;
    chk("coef_en_total", en_cnt, N * pn);
  endtask

  task automatic reset_mid();
    bit found;
    int hits;
    fill_random(6);
    blk[3] = 100;
    found = 1'b0;
    hits = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (coef_en && bit_pos == 4'd3) hits++;
      if (hits == 6) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_plane3", found, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_ctrl", idle_outputs(), '0);
    chk("async_rst_coef", {coeff3, coeff2, coeff1, coeff0}, '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", idle_outputs(), '0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ctrl", idle_outputs(), '0);
    chk("reset_coef", {coeff3, coeff2, coeff1, coeff0}, '0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_ctrl", idle_outputs(), '0);

    // All-zero block: no planes, zero_block with done.
    clear_blk();
    run_block(0);

    // Single unit coefficient at row 3, column 7.
    clear_blk();
    blk[7*4+3] = 1;
    run_block(0);

    // Saturating most-negative value, -1, and a start re-pulse during EMIT.
    clear_blk();
    blk[0] = -32768;
    blk[1] = -1;
    blk[5*4+2] = 100;
    run_block(N + 7);

    for (int i = 0; i < 6; i++) begin
      fill_random(int'($urandom_range(0, 8)));
      run_block((i % 2 == 1) ? N + 2 + int'($urandom_range(0, N)) : 0);
    end

    reset_mid();
    fill_random(5);
    run_block(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
